nco_acq_ctrl: RTL

NCO_ACQ_CTRL -- requirements
Module: nco_acq_ctrl

---
 rtl/nco_ctrl_pkg.sv | 25 ++
 rtl/nco_lock_detect.sv | 79 +++++++
 rtl/nco_acq_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/nco_ctrl_pkg.sv
// nco_ctrl_pkg
//   Shared definitions for the NCO acquisition controller: the state encoding
//   exported on the state output, the default parameter constants, and a small
//   helper used to size the run-length counters.
package nco_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    TRACK = 2'd2
  } state_e;

  localparam int          DEF_WIDTH        = 16;
  localparam logic [15:0] DEF_BASE_INC     = 16'h4000;
  localparam logic [15:0] DEF_SWEEP_STEP   = 16'h0010;
  localparam logic [15:0] DEF_SWEEP_SPAN   = 16'h0400;
  localparam logic [15:0] DEF_LOCK_THRESH  = 16'h0200;
  localparam int          DEF_LOCK_COUNT   = 64;
  localparam int          DEF_UNLOCK_COUNT = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nco_lock_detect.sv
// nco_lock_detect
//   Classifies each qualified error sample as good (|err| < LOCK_THRESH) or bad
//   and keeps saturating run lengths of consecutive good and bad samples.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   err         signed error sample, WIDTH bits
//   valid       sample qualifier; counters hold when low
//   clear       zero both counters (wins over valid)
//   good_hit    this sample completes a run of LOCK_COUNT good samples
//   bad_hit     this sample completes a run of UNLOCK_COUNT bad samples
//   sample_bad  this qualified sample is bad
module nco_lock_detect
  import nco_ctrl_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] LOCK_THRESH  = WIDTH'(DEF_LOCK_THRESH),
  parameter int               LOCK_COUNT   = DEF_LOCK_COUNT,
  parameter int               UNLOCK_COUNT = DEF_UNLOCK_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] err,
  input  logic             valid,
  input  logic             clear,
  output logic             good_hit,
  output logic             bad_hit,
  output logic             sample_bad
);

  localparam int CNT_MAX = max_int(LOCK_COUNT, UNLOCK_COUNT);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GOOD_LAST = CW'(LOCK_COUNT - 1);
  localparam logic [CW-1:0] BAD_LAST  = CW'(UNLOCK_COUNT - 1);
  localparam logic [CW-1:0] CNT_SAT   = '1;

  logic [WIDTH:0]  err_ext;
  logic [WIDTH:0]  err_mag;
  logic            is_good;
  logic [CW-1:0]   good_cnt_q, good_cnt_d;
  logic [CW-1:0]   bad_cnt_q, bad_cnt_d;

  // One extra bit so the most-negative input negates to +2^(WIDTH-1)
  // instead of wrapping back to itself.
  assign err_ext = {err[WIDTH-1], err};
  assign err_mag = err_ext[WIDTH] ? (~err_ext + (WIDTH+1)'(1)) : err_ext;
  assign is_good = (err_mag < {1'b0, LOCK_THRESH});

  assign good_hit   = valid & is_good  & (good_cnt_q >= GOOD_LAST);
  assign bad_hit    = valid & ~is_good & (bad_cnt_q  >= BAD_LAST);
  assign sample_bad = valid & ~is_good;

  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (clear) begin
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else if (valid) begin
      if (is_good) begin
        good_cnt_d = (good_cnt_q == CNT_SAT) ? good_cnt_q : good_cnt_q + CW'(1);
        bad_cnt_d  = '0;
      end else begin
        good_cnt_d = '0;
        bad_cnt_d  = (bad_cnt_q == CNT_SAT) ? bad_cnt_q : bad_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

endmodule

// File: rtl/nco_acq_ctrl.sv
// nco_acq_ctrl
//   Acquisition/tracking controller for an NCO. In SWEEP the frequency offset
//   steps across [-SWEEP_SPAN, +SWEEP_SPAN] on every bad error sample until
//   LOCK_COUNT consecutive good samples are seen; TRACK then freezes the offset
//   until UNLOCK_COUNT consecutive bad samples send it back to SWEEP.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   enable           1 = run, 0 = force IDLE
//   err_tdata/valid  signed loop-filter correction and its qualifier
//   feedback_tdata   BASE_INC + offset + err (mod 2^WIDTH), registered
//   feedback_tvalid  qualifies feedback_tdata, 1 cycle after the sample
//   locked           1 while in TRACK
//   state            IDLE=0, SWEEP=1, TRACK=2
module nco_acq_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] BASE_INC     = WIDTH'(DEF_BASE_INC),
  parameter logic [WIDTH-1:0] SWEEP_STEP   = WIDTH'(DEF_SWEEP_STEP),
  parameter logic [WIDTH-1:0] SWEEP_SPAN   = WIDTH'(DEF_SWEEP_SPAN),
  parameter logic [WIDTH-1:0] LOCK_THRESH  = WIDTH'(DEF_LOCK_THRESH),
  parameter int               LOCK_COUNT   = DEF_LOCK_COUNT,
  parameter int               UNLOCK_COUNT = DEF_UNLOCK_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] err_tdata,
  input  logic             err_tvalid,
  output logic [WIDTH-1:0] feedback_tdata,
  output logic             feedback_tvalid,
  output logic             locked,
  output logic [1:0]       state
);

  localparam logic [WIDTH-1:0] NEG_SPAN = ~SWEEP_SPAN + WIDTH'(1);

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        offset_q, offset_d;
  logic [WIDTH-1:0]        fb_data_q, fb_data_d;
  logic                    fb_valid_q, fb_valid_d;
  logic                    locked_q, locked_d;
  logic                    sample_ok;
  logic                    det_clear;
  logic                    good_hit, bad_hit, sample_bad;
  logic signed [WIDTH:0]   off_step;
  logic signed [WIDTH:0]   span_ext;

  // A sample only counts while running; a sample arriving as enable falls is
  // dropped outright.
  assign sample_ok = err_tvalid & enable & (state_q != IDLE);

  // Counters restart on every state change and stay at zero while idle.
  assign det_clear = ~enable | (state_q == IDLE)
                   | ((state_q == SWEEP) & good_hit)
                   | ((state_q == TRACK) & bad_hit);

  nco_lock_detect #(
    .WIDTH        (WIDTH),
    .LOCK_THRESH  (LOCK_THRESH),
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_COUNT (UNLOCK_COUNT)
  ) u_lock_detect (
    .clk        (clk),
    .rst        (rst),
    .err        (err_tdata),
    .valid      (sample_ok),
    .clear      (det_clear),
    .good_hit   (good_hit),
    .bad_hit    (bad_hit),
    .sample_bad (sample_bad)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; dropping enable beats any same-cycle lock/unlock.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = SWEEP;
        SWEEP:   if (good_hit) state_d = TRACK;
        TRACK:   if (bad_hit)  state_d = SWEEP;
        default: state_d = IDLE;
      endcase
    end
  end

  // Offset step computed one bit wider so the overshoot past +SPAN is visible.
  assign off_step = {offset_q[WIDTH-1], offset_q} + {1'b0, SWEEP_STEP};
  assign span_ext = {1'b0, SWEEP_SPAN};

  // Output/datapath next values; feedback uses the offset before this
  // sample's update.
  always_comb begin
    fb_valid_d = sample_ok;
    fb_data_d  = sample_ok ? (BASE_INC + offset_q + err_tdata) : fb_data_q;
    locked_d   = (state_d == TRACK);
    offset_d   = offset_q;
    if ((state_d == IDLE) || ((state_q == TRACK) && (state_d == SWEEP))) begin
      offset_d = NEG_SPAN;
    end else if ((state_q == SWEEP) && sample_bad) begin
      offset_d = (off_step > span_ext) ? NEG_SPAN : off_step[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q   <= NEG_SPAN;
      fb_data_q  <= BASE_INC;
      fb_valid_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      offset_q   <= offset_d;
      fb_data_q  <= fb_data_d;
      fb_valid_q <= fb_valid_d;
      locked_q   <= locked_d;
    end
  end

  assign feedback_tdata  = fb_data_q;
  assign feedback_tvalid = fb_valid_q;
  assign locked          = locked_q;
  assign state           = state_q;

endmodule
